// File: rtl/lint_l2_pkg.sv
// Shared types and constants for the JTAG lint master to L2 SRAM bridge.
package lint_l2_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hBADC_AB1E;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'h01);
   endfunction

endpackage

// File: rtl/lint_l2_range_chk.sv
// Byte address to bank word offset, plus in-range flag.
// In-range checking only exists when L2_BRIDGE_RANGE_CHECK_EN is defined; otherwise addresses alias.
module lint_l2_range_chk
   import lint_l2_pkg::*;
#(
   parameter logic [31:0]  BASE_ADDR = 32'h1C00_0000,
   parameter int unsigned  MEM_WORDS = 32768,
   localparam int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic [DATA_W-1:0] add_i,
   output logic              in_range_o,
   output logic [ADDR_W-1:0] word_off_o
);

   localparam logic [32:0] BANK_BYTES = 33'(MEM_WORDS) * 33'd4;

   logic [31:0] off_s;

   assign off_s      = add_i - BASE_ADDR;
   assign word_off_o = ADDR_W'(off_s >> 2);

`ifdef L2_BRIDGE_RANGE_CHECK_EN
   assign in_range_o = (add_i >= BASE_ADDR) && ({1'b0, off_s} < BANK_BYTES);
`else
   assign in_range_o = 1'b1;
`endif

endmodule

// File: rtl/lint_l2_bridge.sv
// Lint request/grant/rvalid to single-port L2 SRAM bridge, one access in flight.
// Define L2_BRIDGE_RANGE_CHECK_EN to reject out-of-bank addresses and enable err_o/err_cnt_o.
module lint_l2_bridge
   import lint_l2_pkg::*;
#(
   parameter logic [31:0]  BASE_ADDR = 32'h1C00_0000,
   parameter int unsigned  MEM_WORDS = 32768,
   parameter logic [31:0]  ERR_RDATA = ERR_RDATA_DEF,
   localparam int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [31:0]       add_i,
   input  logic              wen_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        be_i,
   output logic              gnt_o,
   output logic              r_valid_o,
   output logic [31:0]       r_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_ready_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              err_o,
   output logic [7:0]        err_cnt_o
);

   state_e              state_q, state_d;
   logic                gnt_s;
   logic                capture_s;
   logic                in_range_s;
   logic [ADDR_W-1:0]   word_off_s;
   logic                mem_req_q, mem_req_d;
   logic                r_valid_q, r_valid_d;
   logic                err_q, err_d;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [BE_W-1:0]     mem_be_q;
   logic [DATA_W-1:0]   r_rdata_s;

   lint_l2_range_chk #(
      .BASE_ADDR (BASE_ADDR),
      .MEM_WORDS (MEM_WORDS)
   ) u_range_chk (
      .add_i      (add_i),
      .in_range_o (in_range_s),
      .word_off_o (word_off_s)
   );

   assign gnt_s = req_i & ((state_q == IDLE) | (state_q == RESP));

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      capture_s = 1'b0;
      mem_req_d = 1'b0;
      r_valid_d = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (gnt_s) begin
               capture_s = 1'b1;
               if (in_range_s) begin
                  state_d   = ISSUE;
                  mem_req_d = 1'b1;
               end else begin
                  state_d   = RESP;
                  r_valid_d = 1'b1;
                  err_d     = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (mem_ready_i) begin
               state_d   = RESP;
               r_valid_d = 1'b1;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and response/strobe flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mem_req_q <= 1'b0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= mem_req_d;
         r_valid_q <= r_valid_d;
         err_q     <= err_d;
      end
   end

   // Holding registers double as the SRAM address/data bus
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
      end else if (capture_s) begin
         mem_we_q    <= ~wen_i;
         mem_addr_q  <= word_off_s;
         mem_wdata_q <= wdata_i;
         mem_be_q    <= be_i;
      end
   end

   // Read data arrives straight from the macro in the response cycle
   always_comb begin
      r_rdata_s = 32'h0;
      if (!r_valid_q) begin
         r_rdata_s = 32'h0;
      end else if (err_q) begin
         r_rdata_s = ERR_RDATA;
      end else if (mem_we_q) begin
         r_rdata_s = 32'h0;
      end else begin
         r_rdata_s = mem_rdata_i;
      end
   end

`ifdef L2_BRIDGE_RANGE_CHECK_EN
   logic [7:0] err_cnt_q;

   // Saturating count of rejected accesses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_q <= 8'h00;
      end else if (err_q) begin
         err_cnt_q <= sat_inc8(err_cnt_q);
      end
   end

   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;
`else
   assign err_o     = 1'b0;
   assign err_cnt_o = 8'h00;
`endif

   assign gnt_o       = gnt_s;
   assign r_valid_o   = r_valid_q;
   assign r_rdata_o   = r_rdata_s;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_lint_l2_bridge.sv
// Randomized self-checking bench for lint_l2_bridge against a transaction-level memory model.
module tb_lint_l2_bridge;
   import lint_l2_pkg::*;

   localparam logic [31:0] BASE  = 32'h1C00_0000;
   localparam int unsigned WORDS = 32768;
   localparam int          AW    = $clog2(WORDS);

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_i;
   logic [31:0]   add_i;
   logic          wen_i;
   logic [31:0]   wdata_i;
   logic [3:0]    be_i;
   logic          gnt_o;
   logic          r_valid_o;
   logic [31:0]   r_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [3:0]    mem_be_o;
   logic          mem_ready_i;
   logic [31:0]   mem_rdata_i;
   logic          err_o;
   logic [7:0]    err_cnt_o;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   ref_mem [int];
   int            err_model = 0;
   logic [31:0]   sram [WORDS];

   lint_l2_bridge dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .add_i       (add_i),
      .wen_i       (wen_i),
      .wdata_i     (wdata_i),
      .be_i        (be_i),
      .gnt_o       (gnt_o),
      .r_valid_o   (r_valid_o),
      .r_rdata_o   (r_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .mem_ready_i (mem_ready_i),
      .mem_rdata_i (mem_rdata_i),
      .err_o       (err_o),
      .err_cnt_o   (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // SRAM macro: read data valid the cycle after the handshake, garbage otherwise
   always @(posedge clk_i) begin
      if (mem_req_o && mem_ready_i && mem_we_o)
         sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
      if (mem_req_o && mem_ready_i && !mem_we_o)
         mem_rdata_i <= sram[mem_addr_o];
      else
         mem_rdata_i <= $urandom;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_in_range(input logic [31:0] a);
`ifdef L2_BRIDGE_RANGE_CHECK_EN
      longint unsigned la;
      la = longint'(a);
      return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(WORDS));
`else
      return (a == a);
`endif
   endfunction

   function automatic int model_word(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off >> 2) % WORDS);
   endfunction

   function automatic logic [31:0] ref_rd(input int w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   task automatic access(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                         input logic [3:0] be, input int stall, input string tag);
      bit          ok;
      int          w;
      int          lat;
      bit          done;
      bit          seen_req;
      logic [31:0] exp_rd;
      ok = model_in_range(addr);
      w  = model_word(addr);
      exp_rd = !ok ? ERR_RDATA_DEF : (rd ? ref_rd(w) : 32'h0);
      if (ok && !rd) ref_mem[w] = merge(ref_rd(w), wd, be);
      @(negedge clk_i);
      req_i = 1'b1; add_i = addr; wen_i = rd; wdata_i = wd; be_i = be; mem_ready_i = 1'b0;
      #1 check({tag, "_gnt"}, 32'(gnt_o), 32'd1);
      lat = 0; done = 1'b0; seen_req = 1'b0;
      while (!done && lat < 20) begin
         @(negedge clk_i);
         lat++;
         req_i       = ok && (lat - 1 < stall);
         mem_ready_i = (lat - 1 >= stall);
         #1;
         if (req_i) check({tag, "_gnt_stall"}, 32'(gnt_o), 32'd0);
         if (mem_req_o) begin
            seen_req = 1'b1;
            check({tag, "_maddr"}, 32'(mem_addr_o), 32'(w));
            check({tag, "_mwe"}, 32'(mem_we_o), 32'(!rd));
            check({tag, "_mwdata"}, mem_wdata_o, wd);
            check({tag, "_mbe"}, 32'(mem_be_o), 32'(be));
         end
         if (r_valid_o) begin
            done = 1'b1;
            check({tag, "_lat"}, 32'(lat), ok ? 32'(2 + stall) : 32'd1);
            check({tag, "_rdata"}, r_rdata_o, exp_rd);
            check({tag, "_err"}, 32'(err_o), 32'(!ok));
         end
      end
      if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
      check({tag, "_memreq_seen"}, 32'(seen_req), 32'(ok));
      req_i = 1'b0; mem_ready_i = 1'b0;
      if (!ok && err_model < 255) err_model++;
   endtask

   task automatic back_to_back();
      logic [31:0] exp_q [$];
      logic [31:0] e;
      int g = 0;
      int r = 0;
      int cyc = 0;
      @(negedge clk_i);
      while (r < 4 && cyc < 30) begin
         req_i = (g < 4); add_i = BASE + 32'(4 * g); wen_i = 1'b1; mem_ready_i = 1'b1;
         #1;
         if (r_valid_o) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check("b2b_rv_cycle", 32'(cyc), 32'(2 * r + 2));
            check("b2b_rdata", r_rdata_o, e);
            r++;
         end
         if (req_i) begin
            check("b2b_gnt", 32'(gnt_o), 32'(cyc % 2 == 0));
            if (gnt_o) begin
               exp_q.push_back(ref_rd(g));
               g++;
            end
         end
         @(negedge clk_i);
         cyc++;
      end
      if (r < 4) check("b2b_timeout", 32'(r), 32'd4);
      req_i = 1'b0; mem_ready_i = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          w;
      rst_i = 1'b1; req_i = 1'b0; add_i = 32'h0; wen_i = 1'b0; wdata_i = 32'h0;
      be_i = 4'h0; mem_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_gnt", 32'(gnt_o), 32'd0);
      check("rst_memreq", 32'(mem_req_o), 32'd0);
      check("rst_memwe", 32'(mem_we_o), 32'd0);
      check("rst_rvalid", 32'(r_valid_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_rdata", r_rdata_o, 32'h0);
      check("rst_maddr", 32'(mem_addr_o), 32'h0);
      check("rst_mwdata", mem_wdata_o, 32'h0);
      check("rst_mbe", 32'(mem_be_o), 32'h0);
      check("rst_errcnt", 32'(err_cnt_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      req_i = 1'b1;
      #1 check("idle_gnt_follows_req", 32'(gnt_o), 32'd1);
      req_i = 1'b0;

      access(BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, "wr_beef");
      access(BASE + 32'h10, 1'b1, 32'h0, 4'hF, 0, "rd_beef");
      access(BASE + 32'h20, 1'b0, 32'hFFFF_FFFF, 4'hF, 0, "wr_ones");
      access(BASE + 32'h20, 1'b0, 32'h1234_5678, 4'b0011, 0, "wr_part");
      access(BASE + 32'h20, 1'b1, 32'h0, 4'hF, 0, "rd_part");
      access(BASE + 32'h30, 1'b0, 32'hCAFE_F00D, 4'hF, 3, "wr_stall");
      access(BASE + 32'h30, 1'b1, 32'h0, 4'hF, 2, "rd_stall");

      for (int i = 0; i < 64; i++)
         access(BASE + 32'(4 * i), 1'b0, $urandom, 4'hF, int'($urandom_range(0, 1)), "init");

      for (int i = 0; i < 150; i++) begin
         w = int'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * WORDS) + 32'(4 * w)
                                            : BASE - 32'(4 * WORDS) + 32'(4 * w);
         else
            a = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
         access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), "rnd");
      end
      @(negedge clk_i);
      #1 check("rnd_errcnt", 32'(err_cnt_o), 32'(err_model));

      back_to_back();

      access(32'h1C02_0000, 1'b1, 32'h0, 4'hF, 0, "oor_rd");
`ifdef L2_BRIDGE_RANGE_CHECK_EN
      for (int i = 0; i < 300; i++)
         access(32'h1C02_0000 + 32'(4 * i), 1'($urandom_range(0, 1)), $urandom, 4'hF, 0, "oor_sat");
      @(negedge clk_i);
      #1 check("errcnt_sat", 32'(err_cnt_o), 32'hFF);
`else
      @(negedge clk_i);
      #1 check("errcnt_tied", 32'(err_cnt_o), 32'h0);
`endif

      @(negedge clk_i);
      req_i = 1'b1; add_i = BASE + 32'h14; wen_i = 1'b0; wdata_i = 32'h5555_AAAA;
      be_i = 4'hF; mem_ready_i = 1'b0;
      #1 check("rstmid_gnt", 32'(gnt_o), 32'd1);
      @(negedge clk_i);
      req_i = 1'b0;
      #1 check("rstmid_issue", 32'(mem_req_o), 32'd1);
      rst_i = 1'b1;
      #1 check("rstmid_memreq_drop", 32'(mem_req_o), 32'd0);
      req_i = 1'b1;
      #1 check("rstmid_idle_gnt", 32'(gnt_o), 32'd1);
      req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      err_model = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         #1 check("rstmid_no_rvalid", 32'(r_valid_o), 32'd0);
      end
      check("rstmid_errcnt", 32'(err_cnt_o), 32'h0);
      access(BASE + 32'h14, 1'b1, 32'h0, 4'hF, 1, "rstmid_rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
